// File: rtl/uart_pkg.sv
// Shared constants and transmitter state encoding for the UART transmitter.
// Build option: UART_TX_PARITY_EN widens the state to 3 bits and adds a PARITY state.
package uart_pkg;

  localparam int unsigned DATA_BITS  = 8;
  localparam logic        IDLE_LEVEL = 1'b1;
  localparam int unsigned BIT_CNT_W  = 4;
  localparam int unsigned DATA_IDX_W = $clog2(DATA_BITS);

`ifdef UART_TX_PARITY_EN
  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3,
    ST_PARITY = 3'd4
  } tx_state_e;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction
`else
  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;
`endif

endpackage

// File: rtl/uart_baud_div.sv
// Bit-time divider: counts 0..clocks_per_bit-1 and flags (registered) the last
// cycle of each bit (bit_end) and the cycle just before it (near_end).
module uart_baud_div #(
  parameter int unsigned clocks_per_bit = 4
) (
  input  logic clock,
  input  logic tick_reset,
  input  logic clear,
  output logic bit_end,
  output logic near_end
);

  localparam int unsigned CNT_W = (clocks_per_bit > 1) ? $clog2(clocks_per_bit) : 1;
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(clocks_per_bit - 1);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(clocks_per_bit - 2);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bit_end_q, bit_end_d;
  logic             near_end_q, near_end_d;

  // Flags are decoded from the next count so they line up with cnt_q.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear || bit_end_q) begin
      cnt_d = '0;
    end
    bit_end_d  = (cnt_d == LAST);
    near_end_d = (cnt_d == PRE_LAST);
  end

  always_ff @(posedge clock) begin
    if (tick_reset) begin
      cnt_q      <= '0;
      bit_end_q  <= 1'b0;
      near_end_q <= (clocks_per_bit == 2);
    end else begin
      cnt_q      <= cnt_d;
      bit_end_q  <= bit_end_d;
      near_end_q <= near_end_d;
    end
  end

  assign bit_end  = bit_end_q;
  assign near_end = near_end_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start + 8 data bits (LSB first) + 1 or 2 stop bits, all outputs registered.
// Build option: UART_TX_PARITY_EN inserts an even-parity bit between data and stop bits.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned clocks_per_bit = 4,
  parameter int unsigned stop_bits      = 1
) (
  input  logic                 clock,
  input  logic                 tick_reset,
  input  logic [DATA_BITS-1:0] tick_send_data,
  input  logic                 tick_send_request,
  output logic                 get_serial_ret,
  output logic                 get_clear_to_send_ret,
  output logic                 get_idle_ret
);

  localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(DATA_BITS - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_STOP = BIT_CNT_W'(stop_bits - 1);

  tx_state_e              state_q, state_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   serial_q, serial_d;
  logic                   cts_q, cts_d;
  logic                   idle_q, idle_d;
  logic                   accept;
  logic                   bit_end;
  logic                   near_end;
  logic                   baud_clear;

  // The divider sits at zero while idle so START always gets a full bit time.
  assign baud_clear = (state_q == ST_IDLE);

  uart_baud_div #(
    .clocks_per_bit(clocks_per_bit)
  ) u_baud_div (
    .clock     (clock),
    .tick_reset(tick_reset),
    .clear     (baud_clear),
    .bit_end   (bit_end),
    .near_end  (near_end)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    data_d    = data_q;
    serial_d  = IDLE_LEVEL;
    accept    = tick_send_request && cts_q;

    if (accept) begin
      data_d = tick_send_data;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d   = ST_START;
          bit_cnt_d = '0;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = ST_PARITY;
`else
            state_d   = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          state_d   = ST_STOP;
          bit_cnt_d = '0;
        end
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          if (bit_cnt_q == LAST_STOP) begin
            bit_cnt_d = '0;
            state_d   = accept ? ST_START : ST_IDLE;
          end
        end
      end
      default: begin
        state_d   = ST_IDLE;
        bit_cnt_d = '0;
      end
    endcase

    // Outputs are decoded from the next state so the registered line tracks the FSM.
    case (state_d)
      ST_START:  serial_d = ~IDLE_LEVEL;
      ST_DATA:   serial_d = data_d[bit_cnt_d[DATA_IDX_W-1:0]];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: serial_d = even_parity(data_d);
`endif
      default:   serial_d = IDLE_LEVEL;
    endcase

    idle_d = (state_d == ST_IDLE);
    cts_d  = idle_d || ((state_d == ST_STOP) && (bit_cnt_d == LAST_STOP) && near_end);
  end

  always_ff @(posedge clock) begin
    if (tick_reset) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      data_q    <= '0;
      serial_q  <= IDLE_LEVEL;
      cts_q     <= 1'b1;
      idle_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      data_q    <= data_d;
      serial_q  <= serial_d;
      cts_q     <= cts_d;
      idle_q    <= idle_d;
    end
  end

  assign get_serial_ret        = serial_q;
  assign get_clear_to_send_ret = cts_q;
  assign get_idle_ret          = idle_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: hand-written frame table, randomized frames against a frame model,
// and sequences for back-to-back, ignored requests, reset abort and two stop bits.
module tb_uart_tx;

  localparam int CPB = 4;
  localparam int SB  = 1;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NBITS  = 10 + SB - 1 + PAR;
  localparam int CPB2   = 2;
  localparam int SB2    = 2;
  localparam int D2_LEN  = 22 + 2 * PAR;
  localparam int D2_HIGH = 4 + 2 * PAR;

  logic       clock = 1'b0;
  logic       tick_reset;
  logic       tick_send_request;
  logic [7:0] tick_send_data;
  logic       serial, cts, idle;

  logic       reset2;
  logic       req2;
  logic [7:0] data2;
  logic       serial2, cts2, idle2;

  int checks_total  = 0;
  int checks_passed = 0;

  typedef struct {
    logic [7:0] data;
    logic [7:0] seq;  // data bits in transmit order, first-sent bit leftmost
    logic       par;
  } vec_t;

  vec_t vecs[8];

  always #5 clock = ~clock;

  uart_tx #(.clocks_per_bit(CPB), .stop_bits(SB)) dut (
    .clock                (clock),
    .tick_reset           (tick_reset),
    .tick_send_data       (tick_send_data),
    .tick_send_request    (tick_send_request),
    .get_serial_ret       (serial),
    .get_clear_to_send_ret(cts),
    .get_idle_ret         (idle)
  );

  uart_tx #(.clocks_per_bit(CPB2), .stop_bits(SB2)) dut2 (
    .clock                (clock),
    .tick_reset           (reset2),
    .tick_send_data       (data2),
    .tick_send_request    (req2),
    .get_serial_ret       (serial2),
    .get_clear_to_send_ret(cts2),
    .get_idle_ret         (idle2)
  );

  task automatic check_bit(input string nm, input logic act, input logic exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("FAIL %s: actual %b required %b", nm, act, exp);
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    checks_total++;
    if (act == exp) checks_passed++;
    else $display("FAIL %s: actual %0d required %0d", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Line value per bit time: start, data LSB first, optional even parity, stop bits.
  function automatic logic [11:0] model_frame(input logic [7:0] d);
    logic [11:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = d[i];
    if (PAR == 1) f[9] = ^d;
    return f;
  endfunction

  function automatic logic [11:0] table_frame(input vec_t v);
    logic [11:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int k = 1; k <= 8; k++) f[k] = v.seq[8-k];
    if (PAR == 1) f[9] = v.par;
    return f;
  endfunction

  task automatic check_idle(input string nm);
    check_bit({nm, "_idle_serial"}, serial, 1'b1);
    check_bit({nm, "_idle_cts"}, cts, 1'b1);
    check_bit({nm, "_idle_idle"}, idle, 1'b1);
  endtask

  task automatic wait_cts(input string nm);
    int n;
    n = 0;
    while (!cts && n < 200) begin
      step();
      n++;
    end
    check_bit({nm, "_cts_ready"}, cts, 1'b1);
  endtask

  // Walks one frame starting at its first START cycle; request/data for the next edge set in the final cycle.
  task automatic walk_frame(input string nm, input logic [11:0] bits, input bit noise,
                            input logic nreq, input logic [7:0] ndata);
    int last;
    last = NBITS * CPB - 1;
    for (int c = 0; c <= last; c++) begin
      check_bit($sformatf("%s_serial_c%0d", nm, c), serial, bits[c / CPB]);
      check_bit($sformatf("%s_cts_c%0d", nm, c), cts, (c == last));
      check_bit($sformatf("%s_idle_c%0d", nm, c), idle, 1'b0);
      if (c == last) begin
        tick_send_request = nreq;
        tick_send_data    = ndata;
      end else if (noise) begin
        tick_send_request = 1'($urandom_range(0, 1));
        tick_send_data    = 8'hFF;
      end
      step();
    end
  endtask

  task automatic send(input string nm, input logic [7:0] d, input logic [11:0] bits, input bit noise);
    wait_cts(nm);
    tick_send_data    = d;
    tick_send_request = 1'b1;
    step();
    tick_send_request = 1'b0;
    walk_frame(nm, bits, noise, 1'b0, 8'h00);
    check_idle(nm);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin
    logic [11:0] bits;
    logic [11:0] exp2;
    logic [7:0]  d;
    int          cyc;
    int          high_run;

    tick_reset = 1'b1; tick_send_request = 1'b0; tick_send_data = 8'h00;
    reset2     = 1'b1; req2              = 1'b0; data2          = 8'h00;

    vecs[0] = '{data: 8'h48, seq: 8'b0001_0010, par: 1'b0};
    vecs[1] = '{data: 8'h49, seq: 8'b1001_0010, par: 1'b1};
    vecs[2] = '{data: 8'h00, seq: 8'b0000_0000, par: 1'b0};
    vecs[3] = '{data: 8'hFF, seq: 8'b1111_1111, par: 1'b0};
    vecs[4] = '{data: 8'h01, seq: 8'b1000_0000, par: 1'b1};
    vecs[5] = '{data: 8'h80, seq: 8'b0000_0001, par: 1'b1};
    vecs[6] = '{data: 8'hA5, seq: 8'b1010_0101, par: 1'b0};
    vecs[7] = '{data: 8'h3C, seq: 8'b0011_1100, par: 1'b0};

    step();
    check_idle("reset");
    check_bit("reset2_serial", serial2, 1'b1);
    check_bit("reset2_cts", cts2, 1'b1);
    check_bit("reset2_idle", idle2, 1'b1);
    step();
    tick_reset = 1'b0;
    reset2     = 1'b0;
    step();
    check_idle("post_reset");

    for (int i = 0; i < 8; i++) begin
      send($sformatf("vec%0d", i), vecs[i].data, table_frame(vecs[i]), 1'b0);
    end

    // Requests with 0xFF while a frame is in flight must not disturb it or queue a frame.
    send("ignored_req", 8'h3C, model_frame(8'h3C), 1'b1);

    // Request held high across two frames: the second START follows the last stop cycle directly.
    wait_cts("b2b");
    tick_send_data    = 8'h55;
    tick_send_request = 1'b1;
    step();
    walk_frame("b2b_55", model_frame(8'h55), 1'b0, 1'b1, 8'hAA);
    tick_send_request = 1'b0;
    walk_frame("b2b_aa", model_frame(8'hAA), 1'b0, 1'b0, 8'h00);
    check_idle("b2b");

    // Reset during data bit 3 of a 0x00 frame, with a request present on the reset edge.
    wait_cts("rst_mid");
    tick_send_data    = 8'h00;
    tick_send_request = 1'b1;
    step();
    tick_send_request = 1'b0;
    bits = model_frame(8'h00);
    for (int c = 0; c <= 4 * CPB + 1; c++) begin
      check_bit($sformatf("rst_mid_serial_c%0d", c), serial, bits[c / CPB]);
      check_bit($sformatf("rst_mid_idle_c%0d", c), idle, 1'b0);
      if (c == 4 * CPB + 1) begin
        tick_reset        = 1'b1;
        tick_send_request = 1'b1;
        tick_send_data    = 8'h77;
      end
      step();
    end
    tick_reset        = 1'b0;
    tick_send_request = 1'b0;
    check_idle("rst_mid_after");
    step();
    check_idle("rst_mid_settled");

    // Reset and request on the same edge while idle: the byte is dropped.
    tick_reset        = 1'b1;
    tick_send_request = 1'b1;
    tick_send_data    = 8'h77;
    step();
    tick_reset        = 1'b0;
    tick_send_request = 1'b0;
    check_idle("rst_prio");
    step();
    check_idle("rst_prio_next");
    send("after_rst", 8'h41, model_frame(8'h41), 1'b0);

    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 3)) step();
      d = 8'($urandom);
      send($sformatf("rand%0d_%02h", i, d), d, model_frame(d), 1'($urandom_range(0, 1)));
    end

    // Two stop bits at two clocks per bit, byte 0x01.
`ifdef UART_TX_PARITY_EN
    exp2 = 12'b1110_0000_0010;
`else
    exp2 = 12'b0110_0000_0010;
`endif
    check_bit("d2_cts_ready", cts2, 1'b1);
    data2 = 8'h01;
    req2  = 1'b1;
    step();
    req2     = 1'b0;
    cyc      = 0;
    high_run = 0;
    while (!idle2 && cyc < 100) begin
      check_bit($sformatf("d2_serial_c%0d", cyc), serial2,
                (cyc / CPB2 < 12) ? exp2[cyc / CPB2] : 1'b1);
      check_bit($sformatf("d2_cts_c%0d", cyc), cts2, (cyc == D2_LEN - 1));
      if (serial2) high_run++;
      else high_run = 0;
      if (cyc == D2_LEN - 1) check_int("d2_high_before_cts", high_run, D2_HIGH);
      step();
      cyc++;
    end
    check_int("d2_frame_len", cyc, D2_LEN);
    check_bit("d2_end_serial", serial2, 1'b1);
    check_bit("d2_end_cts", cts2, 1'b1);
    check_bit("d2_end_idle", idle2, 1'b1);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
